// File: rtl/clkdiv_prog.sv
// clkdiv_prog -- multi-channel runtime-programmable even-ratio clock divider.
//
// Each channel divides clk_in by 2*(thr+1). clk_out[i] is a registered square
// wave; tick[i] is high for one cycle whenever clk_out[i] takes a new value.
// A new threshold is accepted through a valid/ready port into a one-deep
// per-channel holding register. It becomes active at that channel's next
// half-period boundary, so the half-period in progress always completes.
//
// Ports:
//   clk_in                 sole clock, rising edge
//   rst                    asynchronous active-high reset
//   en[NUM_CH]             per-channel run enable (low = freeze counter/output)
//   ld_valid/ld_ch/ld_value threshold load request
//   ld_ready               combinational: target channel exists and has no
//                          pending load
//   clk_out[NUM_CH]        divided clocks (reset to 1)
//   tick[NUM_CH]           edge strobes (reset to 0)
//   resync[NUM_CH]         only when CLKDIV_PROG_RESYNC_EN is defined: forces
//                          the channel back to the start of a high half-period
//
// Optional feature macro: CLKDIV_PROG_RESYNC_EN.

module clkdiv_prog_ch #(
    parameter int CNT_W             = 32,
    parameter int DEFAULT_THRESHOLD = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
`ifdef CLKDIV_PROG_RESYNC_EN
    input  logic             resync,
`endif
    input  logic             ld_we,
    input  logic [CNT_W-1:0] ld_value,
    output logic             pend,
    output logic             clk_out,
    output logic             tick
);
    localparam logic [CNT_W-1:0] THR_RST = CNT_W'(DEFAULT_THRESHOLD);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] thr_pend;
    logic             boundary;
    logic             sync;

    // >= rather than == so a counter left above a freshly lowered threshold
    // still terminates on the next enabled cycle.
    assign boundary = en && (cnt >= thr);

`ifdef CLKDIV_PROG_RESYNC_EN
    assign sync = resync;
`else
    assign sync = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            thr      <= THR_RST;
            thr_pend <= '0;
            pend     <= 1'b0;
            clk_out  <= 1'b1;
            tick     <= 1'b0;
        end else begin
            if (sync) begin
                cnt     <= '0;
                clk_out <= 1'b1;
                tick    <= 1'b0;
            end else if (boundary) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= 1'b1;
            end else begin
                if (en) cnt <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
            // Pending value takes over only where a half-period starts.
            if ((sync || boundary) && pend) begin
                thr  <= thr_pend;
                pend <= 1'b0;
            end
            // ld_we implies pend was clear, so this never collides with the
            // apply above; a load landing on a boundary waits for the next one.
            if (ld_we) begin
                thr_pend <= ld_value;
                pend     <= 1'b1;
            end
        end
    end
endmodule

module clkdiv_prog #(
    parameter int NUM_CH            = 2,
    parameter int CNT_W             = 32,
    parameter int DEFAULT_THRESHOLD = 1,
    localparam int LD_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
`ifdef CLKDIV_PROG_RESYNC_EN
    input  logic [NUM_CH-1:0] resync,
`endif
    input  logic              ld_valid,
    input  logic [LD_W-1:0]   ld_ch,
    input  logic [CNT_W-1:0]  ld_value,
    output logic              ld_ready,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);
    logic [NUM_CH-1:0]    pend;
    // pend widened to the full ld_ch range so out-of-range indices read a
    // defined value; the range test below rejects them anyway.
    logic [2**LD_W-1:0]   pend_pad;
    logic                 ch_ok;

    always_comb begin
        pend_pad             = '0;
        pend_pad[NUM_CH-1:0] = pend;
    end

    assign ch_ok    = ({1'b0, ld_ch} < (LD_W+1)'(NUM_CH));
    assign ld_ready = ch_ok && !pend_pad[ld_ch];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_prog_ch #(
            .CNT_W            (CNT_W),
            .DEFAULT_THRESHOLD(DEFAULT_THRESHOLD)
        ) u_ch (
            .clk_in  (clk_in),
            .rst     (rst),
            .en      (en[i]),
`ifdef CLKDIV_PROG_RESYNC_EN
            .resync  (resync[i]),
`endif
            .ld_we   (ld_valid && ld_ready && (ld_ch == LD_W'(i))),
            .ld_value(ld_value),
            .pend    (pend[i]),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end
endmodule

// File: tb/tb_clkdiv_prog.sv
// Bench for clkdiv_prog: table of per-cycle vectors with hand-derived outputs
// fed through an expected-output queue, plus hand sequences for reset,
// out-of-range load channel, max threshold and (when enabled) resync.
module tb_clkdiv_prog;
    logic        clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst;
    logic [1:0]  en;
    logic        ld_valid;
    logic [0:0]  ld_ch;
    logic [31:0] ld_value;
    logic        ld_ready;
    logic [1:0]  clk_out, tick;

    // second instance: 3 channels, 3-bit counter, default threshold 0
    logic [2:0]  en2;
    logic        ld_valid2;
    logic [1:0]  ld_ch2;
    logic [2:0]  ld_value2;
    logic        ld_ready2;
    logic [2:0]  clk_out2, tick2;

`ifdef CLKDIV_PROG_RESYNC_EN
    logic [1:0]  resync;
    logic [2:0]  resync2;
`endif

    clkdiv_prog #(.NUM_CH(2), .CNT_W(32), .DEFAULT_THRESHOLD(1)) dut (
        .clk_in(clk_in), .rst(rst), .en(en),
`ifdef CLKDIV_PROG_RESYNC_EN
        .resync(resync),
`endif
        .ld_valid(ld_valid), .ld_ch(ld_ch), .ld_value(ld_value),
        .ld_ready(ld_ready), .clk_out(clk_out), .tick(tick)
    );

    clkdiv_prog #(.NUM_CH(3), .CNT_W(3), .DEFAULT_THRESHOLD(0)) dut2 (
        .clk_in(clk_in), .rst(rst), .en(en2),
`ifdef CLKDIV_PROG_RESYNC_EN
        .resync(resync2),
`endif
        .ld_valid(ld_valid2), .ld_ch(ld_ch2), .ld_value(ld_value2),
        .ld_ready(ld_ready2), .clk_out(clk_out2), .tick(tick2)
    );

    typedef struct {
        logic [1:0]  en;
        logic        ldv;
        logic [0:0]  ch;
        logic [31:0] val;
        logic        rdy;   // ld_ready before the edge
        logic [1:0]  clk;   // clk_out after the edge
        logic [1:0]  tk;    // tick after the edge
    } vec_t;

    typedef struct {
        logic [1:0] clk;
        logic [1:0] tk;
        string      nm;
    } exp_t;

    vec_t vecs[24];
    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one edge of the main DUT: push expectation, clock, pop and compare
    task automatic step(input string nm, input logic [1:0] eclk, input logic [1:0] etk);
        exp_t e;
        sbq.push_back('{eclk, etk, nm});
        @(posedge clk_in); #1;
        e = sbq.pop_front();
        chk({e.nm, " clk_out"}, 32'(clk_out), 32'(e.clk));
        chk({e.nm, " tick"},    32'(tick),    32'(e.tk));
    endtask

    // edges until tick[bit] of the selected DUT rises; returns count, 0 on timeout
    task automatic edges_to_tick(input bit second, input int b, output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_in); #1;
            if (second ? tick2[b] : tick[b]) begin
                n = k;
                return;
            end
        end
    endtask

    initial begin
        int n;
        //        en     ldv  ch    val  rdy   clk    tick
        vecs[0]  = '{2'b11, 1'b0, 1'b0, 0, 1'b1, 2'b11, 2'b00};
        vecs[1]  = '{2'b11, 1'b0, 1'b0, 0, 1'b1, 2'b00, 2'b11};
        vecs[2]  = '{2'b11, 1'b1, 1'b0, 3, 1'b1, 2'b00, 2'b00}; // load ch0=3
        vecs[3]  = '{2'b11, 1'b1, 1'b0, 7, 1'b0, 2'b11, 2'b11}; // stalled 2nd load
        vecs[4]  = '{2'b11, 1'b0, 1'b0, 0, 1'b1, 2'b11, 2'b00};
        vecs[5]  = '{2'b11, 1'b0, 1'b0, 0, 1'b1, 2'b01, 2'b10};
        vecs[6]  = '{2'b11, 1'b0, 1'b0, 0, 1'b1, 2'b01, 2'b00};
        vecs[7]  = '{2'b11, 1'b0, 1'b0, 0, 1'b1, 2'b10, 2'b11}; // ch0 4-cycle half
        vecs[8]  = '{2'b11, 1'b1, 1'b1, 0, 1'b1, 2'b10, 2'b00}; // load ch1=0
        vecs[9]  = '{2'b11, 1'b0, 1'b1, 0, 1'b0, 2'b00, 2'b10};
        vecs[10] = '{2'b11, 1'b0, 1'b1, 0, 1'b1, 2'b10, 2'b10};
        vecs[11] = '{2'b11, 1'b0, 1'b1, 0, 1'b1, 2'b01, 2'b11};
        vecs[12] = '{2'b01, 1'b0, 1'b1, 0, 1'b1, 2'b01, 2'b00}; // ch1 disabled
        vecs[13] = '{2'b01, 1'b1, 1'b1, 2, 1'b1, 2'b01, 2'b00}; // load ch1=2
        vecs[14] = '{2'b01, 1'b0, 1'b1, 0, 1'b0, 2'b01, 2'b00};
        vecs[15] = '{2'b01, 1'b0, 1'b1, 0, 1'b0, 2'b00, 2'b01};
        vecs[16] = '{2'b01, 1'b0, 1'b1, 0, 1'b0, 2'b00, 2'b00};
        vecs[17] = '{2'b11, 1'b0, 1'b1, 0, 1'b0, 2'b10, 2'b10}; // resume, apply 2
        vecs[18] = '{2'b11, 1'b0, 1'b1, 0, 1'b1, 2'b10, 2'b00};
        vecs[19] = '{2'b11, 1'b0, 1'b1, 0, 1'b1, 2'b11, 2'b01};
        vecs[20] = '{2'b11, 1'b0, 1'b1, 0, 1'b1, 2'b01, 2'b10};
        vecs[21] = '{2'b11, 1'b0, 1'b1, 0, 1'b1, 2'b01, 2'b00};
        vecs[22] = '{2'b11, 1'b0, 1'b1, 0, 1'b1, 2'b01, 2'b00};
        vecs[23] = '{2'b11, 1'b0, 1'b1, 0, 1'b1, 2'b10, 2'b11}; // ch1 3-cycle half

        rst = 1'b1; en = 2'b11; ld_valid = 1'b0; ld_ch = 1'b0; ld_value = '0;
        en2 = 3'b001; ld_valid2 = 1'b0; ld_ch2 = 2'd0; ld_value2 = '0;
`ifdef CLKDIV_PROG_RESYNC_EN
        resync = '0; resync2 = '0;
`endif
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset clk_out", 32'(clk_out), 32'h3);
        chk("reset tick", 32'(tick), 32'h0);
        chk("reset ld_ready", 32'(ld_ready), 32'h1);

        @(negedge clk_in); rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            en = vecs[i].en; ld_valid = vecs[i].ldv;
            ld_ch = vecs[i].ch; ld_value = vecs[i].val;
            #1;
            chk($sformatf("vec%0d ld_ready", i), 32'(ld_ready), 32'(vecs[i].rdy));
            step($sformatf("vec%0d", i), vecs[i].clk, vecs[i].tk);
            @(negedge clk_in);
        end

        // asynchronous reset between edges with a load pending on ch0
        ld_valid = 1'b1; ld_ch = 1'b0; ld_value = 32'd5;
        @(posedge clk_in); #1;
        ld_valid = 1'b0;
        chk("pre-rst pending ld_ready", 32'(ld_ready), 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("async rst clk_out", 32'(clk_out), 32'h3);
        chk("async rst tick", 32'(tick), 32'h0);
        chk("async rst drops pending", 32'(ld_ready), 32'h1);
        @(negedge clk_in); rst = 1'b0;
        step("post-rst e1", 2'b11, 2'b00);
        step("post-rst e2", 2'b00, 2'b11);
        step("post-rst e3", 2'b00, 2'b00);
        step("post-rst e4", 2'b11, 2'b11);

        // 3-channel instance: out-of-range channel is never ready and ignored
        @(negedge clk_in);
        ld_valid2 = 1'b1; ld_ch2 = 2'd3; ld_value2 = 3'd5;
        #1 chk("ch3 out of range ld_ready", 32'(ld_ready2), 32'h0);
        @(negedge clk_in); ld_valid2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ld_ch2 = 2'(c);
            #1 chk($sformatf("ch%0d unaffected ld_ready", c), 32'(ld_ready2), 32'h1);
        end
        chk("thr0 tick continuous", 32'(tick2[0]), 32'h1);

        // maximum threshold 7 on a 3-bit counter: half-period of 8 edges
        @(negedge clk_in);
        ld_valid2 = 1'b1; ld_ch2 = 2'd0; ld_value2 = 3'd7;
        @(posedge clk_in); #1;
        ld_valid2 = 1'b0;
        chk("max thr load edge still thr0", 32'(tick2[0]), 32'h1);
        @(posedge clk_in); #1;
        chk("max thr apply edge", 32'(tick2[0]), 32'h1);
        edges_to_tick(1'b1, 0, n);
        chk("max thr half-period 1", 32'(n), 32'd8);
        edges_to_tick(1'b1, 0, n);
        chk("max thr half-period 2", 32'(n), 32'd8);

`ifdef CLKDIV_PROG_RESYNC_EN
        // resync applies a pending load and realigns ch0
        @(negedge clk_in);
        ld_valid = 1'b1; ld_ch = 1'b0; ld_value = 32'd5;
        @(negedge clk_in);
        ld_valid = 1'b0; resync = 2'b01;
        @(posedge clk_in); #1;
        resync = 2'b00;
        chk("resync1 clk_out0", 32'(clk_out[0]), 32'h1);
        chk("resync1 tick0", 32'(tick[0]), 32'h0);
        chk("resync1 applied pending", 32'(ld_ready), 32'h1);
        repeat (3) @(posedge clk_in);    // cnt reaches 3
        @(negedge clk_in); resync = 2'b01;
        @(posedge clk_in); #1;
        resync = 2'b00;
        chk("resync2 clk_out0", 32'(clk_out[0]), 32'h1);
        chk("resync2 tick0", 32'(tick[0]), 32'h0);
        edges_to_tick(1'b0, 0, n);
        chk("resync next toggle", 32'(n), 32'd6);
        chk("resync toggle value", 32'(clk_out[0]), 32'h0);
`endif

        chk("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clkdiv_prog.md
# clkdiv_prog

Multi-channel, runtime-programmable clock divider for the audio-visualizer clocking tree. Each channel divides `clk_in` by an even ratio 2·(threshold+1), producing a square `clk_out` and a one-cycle `tick` strobe on every output edge. Thresholds are reloaded through a valid/ready port and applied glitch-free at the channel's next half-period boundary. Replaces fixed-ratio dividers wherever sample-rate or display-refresh clocks must change at runtime.

## Interface
- `NUM_CH`, 2: number of independent divider channels (1..16).
- `CNT_W`, 32: counter and threshold width in bits.
- `DEFAULT_THRESHOLD`, 1: threshold loaded into every channel at reset.
- `clk_in` in 1: sole clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in NUM_CH: per-channel run enable.
- `ld_valid` in 1: threshold load request.
- `ld_ch` in $clog2(NUM_CH) (min 1): target channel of the load.
- `ld_value` in CNT_W: new threshold.
- `ld_ready` out 1: load accepted this cycle when high together with `ld_valid`.
- `clk_out` out NUM_CH: divided clocks, registered.
- `tick` out NUM_CH: one-cycle strobe, registered, high in the cycle `clk_out[i]` takes a new value.

## Operation
- Per-channel state: `cnt` (CNT_W), active `thr`, `thr_pend`, `pend` flag.
- Reset values:
  - `cnt` = 0.
  - `clk_out` = all ones.
  - `tick` = 0.
  - `thr` = DEFAULT_THRESHOLD.
  - `pend` = 0.
- Boundary for channel i is `en[i] && cnt >= thr`. At the boundary:
  - `cnt` <= 0.
  - `clk_out[i]` toggles.
  - `tick[i]` <= 1.
  - If `pend`, then `thr` <= `thr_pend` and `pend` <= 0.
- `en[i]` high, not at the boundary: `cnt` <= `cnt`+1 and `tick[i]` <= 0.
- `en[i]` low: `cnt` and `clk_out[i]` hold and `tick[i]` <= 0. A pending load stays pending.
- The comparison is unsigned `>=`, so a counter above the threshold recovers at the next cycle.
- Load handshake:
  - `ld_ready` = (`ld_ch` < NUM_CH) && !`pend[ld_ch]`. It is combinational on `ld_ch` and the registered `pend`.
  - On transfer (`ld_valid && ld_ready`): `thr_pend[ld_ch]` <= `ld_value` and `pend[ld_ch]` <= 1.
  - At most one pending value per channel. Further loads to that channel stall until the pending value is applied.
  - A transfer in the same cycle as that channel's boundary does not affect that boundary. The new value is applied at the following boundary.
  - An out-of-range `ld_ch` is never ready, and the request is ignored.
- Threshold 0 gives `clk_out` toggling every enabled cycle (divide by 2), with `tick` continuously high.
- The maximum threshold 2^CNT_W−1 is legal. `cnt` never wraps because the boundary triggers at equality.

## Timing
- Half-period = thr+1 enabled cycles. Full period = 2·(thr+1).
- After reset release with `en` high:
  - First toggle (`clk_out` 1→0, `tick`=1) is at rising edge number DEFAULT_THRESHOLD+1.
  - The default of 1 puts the first toggle at edge 2.
- Load latency: the new ratio governs the half-period that starts at the first boundary after the accept edge. The old half-period always completes.
- `rst` mid-operation immediately forces the reset values and discards pending loads, with no clock needed.

## Configuration
- `CLKDIV_PROG_RESYNC_EN` defined:
  - Adds input `resync` (NUM_CH bits).
  - A high `resync[i]` at an edge forces `cnt` <= 0, `clk_out[i]` <= 1 and `tick[i]` <= 0.
  - If `pend`, that edge also sets `thr` <= `thr_pend` and `pend` <= 0.
  - `resync` has priority over the boundary and over `en`.
- Undefined: the `resync` port and its logic are absent, and channels realign only via `rst`.

## Test plan
- Reset and run, NUM_CH=2, `en`=2'b11, default threshold 1 → both `clk_out` toggle every 2 cycles with period 4, and `tick` pulses on edges 2, 4, 6, ….
- Load ch0 value 3 mid half-period → `ld_ready` drops for ch0 the next cycle. Current half-period finishes at 2 cycles, later half-periods are 4 cycles, and ch1 is unchanged.
- Second load to ch0 while pending → `ld_ready`=0 and `thr_pend` is unchanged until the boundary. `ld_ready` returns high the cycle after the boundary applies the value.
- Load value 0, then drop `en[1]` for 5 cycles → ch1 toggles every cycle. While disabled, `clk_out[1]` holds, `tick[1]`=0 and `cnt` is frozen, and counting resumes from the held value.
- Assert `rst` between edges with a pending load → outputs go to 1/0 immediately, and threshold 1 behaviour resumes after release.
- With `CLKDIV_PROG_RESYNC_EN` defined, threshold 5, pulse `resync[0]` at cnt=3 → next edge `clk_out[0]`=1 and `cnt`=0, and the next toggle follows 6 cycles later.
